sincos_phase_seq: RTL and testbench



---
 rtl/sincos_phase_seq.sv | 177 +++++++++++++++++
 tb/tb_sincos_phase_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_phase_seq.sv
// Phase sequencer around a 16-iteration CORDIC sin/cos core: folds the phase into +/-90 deg,
// launches the core, restores quadrant sign. Optional angle dither via `CORDIC_DITHER_EN.
module sincos_phase_seq #(
    parameter int unsigned CORDIC_LAT = 18,
    parameter int unsigned PHASE_MOD  = 92160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] step,
    output logic [23:0] cordic_angle,
    output logic        cordic_start,
    input  logic [23:0] cordic_cos,
    input  logic [23:0] cordic_sin,
    output logic [23:0] cos_out,
    output logic [23:0] sin_out,
    output logic [23:0] phase_out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned CntW     = $clog2(CORDIC_LAT) + 1;
    localparam logic [23:0] Mod      = 24'(PHASE_MOD);
    localparam logic [23:0] Quarter  = 24'(PHASE_MOD / 4);
    localparam logic [23:0] Half     = 24'(PHASE_MOD / 2);
    localparam logic [23:0] ThreeQtr = 24'(3 * PHASE_MOD / 4);
    localparam logic [CntW-1:0] CntLast = CntW'(CORDIC_LAT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

    state_e         state_q, state_d;
    logic [23:0]    p_q, p_d;
    logic [23:0]    angle_q, angle_d;
    logic           neg_q, neg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [23:0]    cos_q, cos_d;
    logic [23:0]    sin_q, sin_d;
    logic [23:0]    phase_q, phase_d;

    logic [23:0]    fold_angle;
    logic           fold_neg;
    logic [23:0]    angle_src;
    logic [23:0]    step_clamped;
    logic [23:0]    p_sum;
    logic [23:0]    p_next;
    logic [23:0]    cos_fixed;
    logic           cnt_last;

    always_comb begin
        fold_angle = p_q;
        fold_neg   = 1'b0;
        if (p_q <= Quarter) begin
            fold_angle = p_q;
        end else if (p_q < ThreeQtr) begin
            fold_angle = Half - p_q;
            fold_neg   = 1'b1;
        end else begin
            fold_angle = p_q - Mod;
        end
    end

`ifdef CORDIC_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic [23:0] dith_sum;

    // Fibonacci taps 16,14,13,11 in right-shift form.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StLaunch) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
    end

    always_comb begin
        dith_sum  = fold_angle + {23'd0, lfsr_q[0]};
        angle_src = dith_sum;
        if ($signed(dith_sum) > $signed(Quarter)) begin
            angle_src = Quarter;
        end else if ($signed(dith_sum) < -$signed(Quarter)) begin
            angle_src = 24'd0 - Quarter;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign angle_src = fold_angle;
`endif

    // Both operands stay below PHASE_MOD, so one conditional subtract wraps the sum.
    assign step_clamped = (step >= Mod) ? (Mod - 24'd1) : step;
    assign p_sum        = p_q + step_clamped;
    assign p_next       = (p_sum >= Mod) ? (p_sum - Mod) : p_sum;
    assign cos_fixed    = (cordic_cos == 24'h800000) ? 24'h7FFFFF : (24'd0 - cordic_cos);
    assign cnt_last     = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (en) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait:   if (cnt_last) state_d = StHold;
            StHold:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        p_d     = p_q;
        angle_d = angle_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        phase_d = phase_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    angle_d = angle_src;
                    neg_d   = fold_neg;
                end
            end
            StLaunch: cnt_d = '0;
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    sin_d   = cordic_sin;
                    cos_d   = neg_q ? cos_fixed : cordic_cos;
                    phase_d = p_q;
                    p_d     = p_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cordic_start = (state_q == StLaunch);
        out_valid    = (state_q == StHold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            angle_q <= angle_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            phase_q <= phase_d;
        end
    end

    assign cordic_angle = angle_q;
    assign cos_out      = cos_q;
    assign sin_out      = sin_q;
    assign phase_out    = phase_q;

endmodule

// File: tb/tb_sincos_phase_seq.sv
// Directed bench for sincos_phase_seq with a behavioural 16-cycle CORDIC stand-in.
module tb_sincos_phase_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] step;
    logic [23:0] cordic_angle;
    logic        cordic_start;
    logic [23:0] cordic_cos;
    logic [23:0] cordic_sin;
    logic [23:0] cos_out;
    logic [23:0] sin_out;
    logic [23:0] phase_out;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic       force_cos = 1'b0;
    logic [4:0] core_cnt  = 5'd31;

`ifdef CORDIC_DITHER_EN
    localparam logic [23:0] FirstAngle = 24'd1;
`else
    localparam logic [23:0] FirstAngle = 24'd0;
`endif

    always #5 clk = ~clk;

    sincos_phase_seq dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .step         (step),
        .cordic_angle (cordic_angle),
        .cordic_start (cordic_start),
        .cordic_cos   (cordic_cos),
        .cordic_sin   (cordic_sin),
        .cos_out      (cos_out),
        .sin_out      (sin_out),
        .phase_out    (phase_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    function automatic logic [23:0] model_val(input logic [23:0] ang, input bit is_sin);
        real r;
        real x;
        r = (real'($signed(ang)) / 256.0) * 3.14159265358979 / 180.0;
        x = 255.0 * (is_sin ? $sin(r) : $cos(r));
        return 24'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
    endfunction

    // Results are garbage until 16 cycles after the launch strobe.
    always @(posedge clk) begin
        if (cordic_start) core_cnt <= 5'd0;
        else if (core_cnt != 5'd31) core_cnt <= core_cnt + 5'd1;
    end

    always_comb begin
        if (core_cnt < 5'd16) begin
            cordic_cos = 24'h5A5A5A;
            cordic_sin = 24'hA5A5A5;
        end else begin
            cordic_cos = force_cos ? 24'h800000 : model_val(cordic_angle, 1'b0);
            cordic_sin = model_val(cordic_angle, 1'b1);
        end
    end

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; out_ready = 1'b1; force_cos = 1'b0; step = 24'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        logic [5:0] got;
        got = {cos_out != 0, sin_out != 0, phase_out != 0, cordic_angle != 0,
               cordic_start, out_valid};
        n_cmp++;
        if (got !== 6'b0) begin
            n_err++;
            $display("FAIL %s: nonzero-output flags got %b want 000000", nm, got);
        end
    endtask

    task automatic do_sample(input string nm, input logic [23:0] e_phase,
                             input logic [23:0] e_angle, input logic [23:0] e_cos,
                             input logic [23:0] e_sin);
        int n;
        n = 0;
        while (cordic_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (cordic_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: cordic_start got %b want 1", nm, cordic_start);
        end
        n_cmp++;
        if (cordic_angle !== e_angle) begin
            n_err++;
            $display("FAIL %s_angle: got %0d want %0d", nm, $signed(cordic_angle),
                     $signed(e_angle));
        end
        @(negedge clk);
        n = 1;
        n_cmp++;
        if (cordic_start !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pulse: cordic_start one cycle later got %b want 0", nm,
                     cordic_start);
        end
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 19) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want 19 cycles", nm, n);
        end
        n_cmp++;
        if (phase_out !== e_phase) begin
            n_err++;
            $display("FAIL %s_phase: got %0d want %0d", nm, phase_out, e_phase);
        end
        n_cmp++;
        if (cos_out !== e_cos) begin
            n_err++;
            $display("FAIL %s_cos: got %0d want %0d", nm, $signed(cos_out), $signed(e_cos));
        end
        n_cmp++;
        if (sin_out !== e_sin) begin
            n_err++;
            $display("FAIL %s_sin: got %0d want %0d", nm, $signed(sin_out), $signed(e_sin));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; step = 24'd5;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        apply_reset();
        en = 1'b1;
        do_sample("basic", 24'd0, FirstAngle, 24'd255, 24'd0);
        en = 1'b0;
    endtask

    task automatic test_quadrants();
        apply_reset();
        step = 24'd23040;
        en   = 1'b1;
        do_sample("q0", 24'd0,     24'd0,       24'd255,      24'd0);
        do_sample("q1", 24'd23040, 24'd23040,   24'd0,        24'd255);
        do_sample("q2", 24'd46080, 24'd0,       24'hFFFF01,   24'd0);
        do_sample("q3", 24'd69120, 24'hFFA600,  24'd0,        24'hFFFF01);
        en = 1'b0;
    endtask

    task automatic test_clamp();
        apply_reset();
        step = 24'd100000;
        en   = 1'b1;
        do_sample("clamp0", 24'd0,     24'd0,      24'd255, 24'd0);
        do_sample("clamp1", 24'd92159, 24'hFFFFFF, 24'd255, 24'd0);
        do_sample("clamp2", 24'd92158, 24'hFFFFFE, 24'd255, 24'd0);
        en = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        step      = 24'd46080;
        force_cos = 1'b1;
        en        = 1'b1;
        do_sample("sat_pos", 24'd0,     24'd0, 24'h800000, 24'd0);
        do_sample("sat_neg", 24'd46080, 24'd0, 24'h7FFFFF, 24'd0);
        en        = 1'b0;
        force_cos = 1'b0;
    endtask

    task automatic test_backpressure();
        logic ok;
        apply_reset();
        step      = 24'd23040;
        out_ready = 1'b0;
        en        = 1'b1;
        do_sample("bp_s1", 24'd0, 24'd0, 24'd255, 24'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok = out_valid && !cordic_start && cos_out == 24'd255 && sin_out == 24'd0
                 && phase_out == 24'd0;
            n_cmp++;
            if (ok !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: stable got %b want 1 (valid=%b start=%b)", i, ok,
                         out_valid, cordic_start);
            end
        end
        out_ready = 1'b1;
        en        = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({cordic_start, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_idle: start/valid got %b want 00", {cordic_start, out_valid});
        end
        en = 1'b1;
        do_sample("bp_s2", 24'd23040, 24'd23040, 24'd0, 24'd255);
        en = 1'b0;
    endtask

    task automatic test_rst_mid_wait();
        int  n;
        logic seen;
        apply_reset();
        step = 24'd23040;
        en   = 1'b1;
        do_sample("abort_s1", 24'd0, 24'd0, 24'd255, 24'd0);
        n = 0;
        while (cordic_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort_rst");
        rst  = 1'b0;
        en   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_novalid: out_valid seen got %b want 0", seen);
        end
        en = 1'b1;
        do_sample("abort_s2", 24'd0, 24'd0, 24'd255, 24'd0);
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; step = 24'd0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_quadrants();
        test_clamp();
        test_saturate();
        test_backpressure();
        test_rst_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
